// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS stage registers: occupancy states,
// the NOP encoding and default payload widths for each stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // PC+4 and instruction travel together through IF/ID
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 148;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

    function automatic logic is_live(input stage_state_e s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer
// so in_ready is registered. Macro PIPE_STAGE_PERF_CNT_EN adds stall/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(MIPS_NOP)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    parameter int                CNT_W     = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    stage_state_e      state, state_next;
    logic [DATA_W-1:0] main_q, main_next;
    logic [DATA_W-1:0] skid_q, skid_next;
    logic              in_ready_q;
    logic              accept, drain;

    assign accept    = in_valid && in_ready_q;
    assign drain     = is_live(state) && out_ready && !stall;
    assign in_ready  = in_ready_q;
    assign out_valid = is_live(state);
    assign out_data  = main_q;

    // Main entry always drives out_data; the skid entry only catches the
    // one extra word that can arrive while the main entry is blocked.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = EMPTY;
            main_next  = FLUSH_VAL;
            skid_next  = FLUSH_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (drain && accept) begin
                        main_next = in_data;
                    end else if (drain) begin
                        state_next = EMPTY;
                        main_next  = FLUSH_VAL;
                    end else if (accept) begin
                        state_next = TWO;
                        skid_next  = in_data;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_next = ONE;
                        main_next  = skid_q;
                        skid_next  = FLUSH_VAL;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = FLUSH_VAL;
                    skid_next  = FLUSH_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_q     <= FLUSH_VAL;
            skid_q     <= FLUSH_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            main_q     <= main_next;
            skid_q     <= skid_next;
            in_ready_q <= (state_next != TWO);
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic stall_inc, flush_inc;

    assign stall_inc = is_live(state) && !drain;
    assign flush_inc = flush && is_live(state);

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table plus a data-order scoreboard.
// Counter checks run when PIPE_STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;
`endif

    int checks = 0;
    int passes = 0;

    logic [63:0] sb[$];
    logic        exp_vld = 1'b0;
    logic        exp_rdy = 1'b1;

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic        st;
        logic        fl;
        logic        ordy;
        logic        ev;
        logic [63:0] ed;
        logic        er;
    } vec_t;

    vec_t vecs[20];

    pipe_stage_reg #(
        .DATA_W    (64),
        .FLUSH_VAL (64'h0)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .CNT_W     (4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic iv, input logic [63:0] id, input logic st,
                                   input logic fl, input logic ordy, input logic ev,
                                   input logic [63:0] ed, input logic er);
        vec_t v;
        v.iv = iv; v.id = id; v.st = st; v.fl = fl; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.er = er;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drives one cycle; drained words are compared against the arrival-order queue.
    task automatic applyStimulus(input vec_t v, input string tag);
        logic drain_exp;
        @(negedge clk);
        in_valid  = v.iv;
        in_data   = v.id;
        stall     = v.st;
        flush     = v.fl;
        out_ready = v.ordy;
        drain_exp = exp_vld && v.ordy && !v.st && !v.fl;
        if (v.fl) begin
            sb.delete();
        end else begin
            if (drain_exp) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL %s_drain: got %h expected no word", tag, out_data);
                end else begin
                    checkOutput({tag, "_drain"}, out_data, sb.pop_front());
                end
            end
            if (v.iv && exp_rdy) sb.push_back(v.id);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'(v.ev));
        checkOutput({tag, "_out_data"},  out_data, v.ed);
        checkOutput({tag, "_in_ready"},  64'(in_ready), 64'(v.er));
        exp_vld = v.ev;
        exp_rdy = v.er;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rst%0d_out_valid", i), 64'(out_valid), 64'd0);
            checkOutput($sformatf("rst%0d_out_data", i), out_data, 64'd0);
            checkOutput($sformatf("rst%0d_in_ready", i), 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        exp_vld = 1'b0;
        exp_rdy = 1'b1;
    endtask

    initial begin
        //                 iv  id        st  fl  ordy ev  ed        er
        vecs[0]  = mkVec(1, 64'hA1, 0, 0, 1, 1, 64'hA1, 1);
        vecs[1]  = mkVec(1, 64'hB2, 0, 0, 1, 1, 64'hB2, 1);
        vecs[2]  = mkVec(1, 64'hC3, 0, 0, 1, 1, 64'hC3, 1);
        vecs[3]  = mkVec(0, 64'h00, 0, 0, 1, 0, 64'h00, 1);
        vecs[4]  = mkVec(1, 64'hD4, 0, 0, 0, 1, 64'hD4, 1);
        vecs[5]  = mkVec(1, 64'hE5, 0, 0, 0, 1, 64'hD4, 0);
        vecs[6]  = mkVec(1, 64'hF6, 0, 0, 0, 1, 64'hD4, 0);
        vecs[7]  = mkVec(0, 64'h00, 0, 0, 1, 1, 64'hE5, 1);
        vecs[8]  = mkVec(0, 64'h00, 0, 0, 1, 0, 64'h00, 1);
        vecs[9]  = mkVec(1, 64'h17, 0, 0, 0, 1, 64'h17, 1);
        vecs[10] = mkVec(1, 64'h28, 0, 0, 0, 1, 64'h17, 0);
        vecs[11] = mkVec(1, 64'h39, 0, 1, 0, 0, 64'h00, 1);
        vecs[12] = mkVec(0, 64'h00, 0, 0, 1, 0, 64'h00, 1);
        vecs[13] = mkVec(1, 64'h4A, 0, 0, 1, 1, 64'h4A, 1);
        vecs[14] = mkVec(1, 64'h5B, 1, 0, 1, 1, 64'h4A, 0);
        vecs[15] = mkVec(0, 64'h00, 1, 0, 1, 1, 64'h4A, 0);
        vecs[16] = mkVec(0, 64'h00, 0, 0, 1, 1, 64'h5B, 1);
        vecs[17] = mkVec(0, 64'h00, 1, 1, 1, 0, 64'h00, 1);
        vecs[18] = mkVec(1, 64'h6C, 0, 0, 1, 1, 64'h6C, 1);
        vecs[19] = mkVec(0, 64'h00, 0, 0, 1, 0, 64'h00, 1);

        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
`ifdef PIPE_STAGE_PERF_CNT_EN
        checkOutput("table_stall_cnt", 64'(stall_cnt), 64'd7);
        checkOutput("table_flush_cnt", 64'(flush_cnt), 64'd2);
`endif

        // Stall holds the output, then stall together with flush empties the stage
        doReset();
`ifdef PIPE_STAGE_PERF_CNT_EN
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
        applyStimulus(mkVec(1, 64'hAAAA, 0, 0, 0, 1, 64'hAAAA, 1), "hold_acc");
        for (int i = 0; i < 3; i++)
            applyStimulus(mkVec(0, 64'h0, 1, 0, 1, 1, 64'hAAAA, 1), $sformatf("hold%0d", i));
`ifdef PIPE_STAGE_PERF_CNT_EN
        checkOutput("hold_stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        applyStimulus(mkVec(0, 64'h0, 1, 1, 1, 0, 64'h0, 1), "stall_flush");
`ifdef PIPE_STAGE_PERF_CNT_EN
        checkOutput("sf_flush_cnt", 64'(flush_cnt), 64'd1);
        checkOutput("sf_stall_cnt", 64'(stall_cnt), 64'd4);
`endif

        // Long stall drives the 4-bit stall counter into saturation
        applyStimulus(mkVec(1, 64'hBBBB, 0, 0, 1, 1, 64'hBBBB, 1), "sat_acc");
        for (int i = 0; i < 20; i++)
            applyStimulus(mkVec(0, 64'h0, 1, 0, 1, 1, 64'hBBBB, 1), $sformatf("sat%0d", i));
`ifdef PIPE_STAGE_PERF_CNT_EN
        checkOutput("sat_stall_cnt", 64'(stall_cnt), 64'd15);
        applyStimulus(mkVec(0, 64'h0, 1, 0, 1, 1, 64'hBBBB, 1), "sat_hold");
        checkOutput("sat_stall_cnt_hold", 64'(stall_cnt), 64'd15);
`endif
        applyStimulus(mkVec(0, 64'h0, 0, 0, 1, 0, 64'h0, 1), "sat_drain");
        checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the pipelined MIPS core; generalises the fixed 32-bit stage registers (stall/flush only) into one reusable block.
- Adds a valid/ready handshake, a 2-entry skid buffer so `in_ready` is registered, a configurable flush value, and per-stage occupancy state.
- Instantiated between every stage pair: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- DATA_W, 64, payload width (e.g. PC+4 concatenated with instr for IF/ID).
- FLUSH_VAL, 0, value loaded into `out_data` on flush/reset (0 = MIPS sll $0 NOP).
- CNT_W, 16, width of performance counters (only used with PERF_CNT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream stage presents `in_data`.
- in_ready  out  1  block can accept; registered output.
- in_data  in  DATA_W  upstream payload.
- stall  in  1  hazard-unit hold; freezes output entry, same as `out_ready`=0.
- flush  in  1  discard all held entries (branch taken/exception).
- out_valid  out  1  `out_data` holds a live instruction.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to next stage.
- stall_cnt  out  CNT_W  cycles with `out_valid`=1 and no transfer (PERF_CNT_EN only).
- flush_cnt  out  CNT_W  flush events that killed at least one valid entry (PERF_CNT_EN only).

Behaviour:
- Reset (rst=1 at posedge): state=EMPTY, `out_valid`=0, `out_data`=FLUSH_VAL, skid entry invalid, `in_ready`=1, counters=0. Reset mid-transfer discards both entries.
- Accept: `in_valid` && `in_ready`.
- Drain: `out_valid` && `out_ready` && !`stall`.
- States:
  - EMPTY: no live entries.
  - ONE: main entry live.
  - TWO: main and skid entries live.
- EMPTY + accept -> ONE; `out_data`=`in_data` next cycle. Latency is 1 cycle.
- ONE:
  - Drain and accept -> ONE with the new data.
  - Drain only -> EMPTY.
  - Accept only -> TWO; new data goes to skid, `in_ready`=0 next cycle.
  - Neither -> hold.
- TWO:
  - Drain -> ONE; skid moves to main, `in_ready`=1 next cycle.
  - No accept is possible in TWO since `in_ready`=0.
- `out_valid`=1 in ONE and TWO, 0 in EMPTY.
- In EMPTY, `out_data` holds FLUSH_VAL, so downstream sees a NOP bubble.
- Flush has the highest priority after rst:
  - Next state EMPTY; `out_data`=FLUSH_VAL, `out_valid`=0, skid cleared, `in_ready`=1.
  - Input presented in the same cycle is dropped, not accepted.
- Flush and stall together: flush wins.
- Stall with `out_ready`=1: no drain, state holds, `out_data` unchanged.
- A stall in ONE may still accept into skid (-> TWO).
- Order-preserving: data leaves in arrival order, with no duplication or loss except on flush/rst.
- Counters (PERF_CNT_EN): saturate at all-ones, no wrap. `flush_cnt` increments only if state != EMPTY when flush is applied.

Optional Feature:
- Macro PIPE_STAGE_PERF_CNT_EN.
- Defined: `stall_cnt` and `flush_cnt` ports and registers exist and behave as above.
- Undefined: both ports are absent, and no counter logic is generated.

Decomposition:
- Shared package pipe_pkg:
  - State enum {EMPTY, ONE, TWO} as a 2-bit typedef.
  - Constant MIPS_NOP = 32'h0000_0000.
  - Default widths for the IF/ID, ID/EX, EX/MEM and MEM/WB payloads.
- One natural sub-module: pipe_sat_counter (CNT_W, inc, clr -> saturating count), instantiated twice under the macro.

Test Plan:
- Reset: hold rst 2 cycles with `in_valid`=1, `in_data`=64'hDEAD -> `out_valid`=0, `out_data`=0, `in_ready`=1; the first accept happens after rst drops.
- Streaming: `out_ready`=1, push A,B,C on consecutive cycles -> `out_data`=A,B,C on cycles +1,+2,+3, `in_ready` stays 1.
- Backpressure: push A,B with `out_ready`=0 -> state TWO, `in_ready`=0 on cycle +2; raise `out_ready` -> A, then B, with `in_ready`=1 one cycle after A drains.
- Flush in TWO: entries A,B live, assert flush with `in_valid`=1, data C -> next cycle `out_valid`=0, `out_data`=0, C is not delivered, and `flush_cnt`=1.
- Stall vs flush: assert stall 3 cycles holding A -> `out_data`=A constant, `stall_cnt`=3. Then assert stall and flush together -> EMPTY.
- Saturation: CNT_W=4, stall for 20 cycles -> `stall_cnt`=15 and holds.
